instr_mem_responder: RTL and testbench

Instruction-memory responder for `simple_cpu`: the memory end of the CPU fetch interface. It accepts a fetch request (address), waits a parameterised number of cycles, then returns the instruction word with a one-cycle valid strobe. A host-side load port lets the bench or boot logic write the program before or between fetches. A saturating fetch counter supports bring-up debug.

---
 rtl/instr_mem_responder.sv | 151 +++++++++++++++
 tb/tb_instr_mem_responder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_responder.sv
// rtl/instr_mem_responder.sv - instruction-memory responder for the simple_cpu fetch port
// Optional feature macro: IMEM_PARITY_EN (per-word even parity, checked on fetch)
module instr_mem_responder #(
  parameter int                ADDR_W      = 8,
  parameter int                DATA_W      = 16,
  parameter int                DEPTH       = 256,
  parameter int                WAIT_CYCLES = 2,
  parameter logic [DATA_W-1:0] HALT_WORD   = 16'hF000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_err,
  output logic              busy,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ack,
  output logic [15:0]       fetch_count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                fetch_valid_q;
  logic [DATA_W-1:0]   fetch_data_q;
  logic                fetch_err_q;
  logic                load_ack_q;
  logic [15:0]         fetch_count_q;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                load_accept;
  logic                fetch_start;
  logic                load_in_range;
  logic                rd_in_range;
  logic [IDX_W-1:0]    wr_idx;
  logic [IDX_W-1:0]    rd_idx;
  logic [DATA_W-1:0]   rd_word;
  logic                par_ok;

  // A load always wins over a simultaneous fetch; the fetch is picked up once load_we drops.
  assign load_accept   = load_we && (state_q == S_IDLE);
  assign fetch_start   = fetch_req && !load_we && (state_q == S_IDLE);
  assign load_in_range = int'(load_addr) < DEPTH;
  assign rd_in_range   = int'(addr_q) < DEPTH;
  assign wr_idx        = load_addr[IDX_W-1:0];
  assign rd_idx        = addr_q[IDX_W-1:0];
  assign rd_word       = mem[rd_idx];

`ifdef IMEM_PARITY_EN
  logic par_mem [DEPTH];

  // Parity bit stored alongside each word; not cleared by reset, like the data array.
  always_ff @(posedge clk) begin
    if (reset && load_accept && load_in_range) par_mem[wr_idx] <= ^load_data;
  end

  assign par_ok = ((^rd_word) == par_mem[rd_idx]);
`else
  assign par_ok = 1'b1;
`endif

  // Program storage: written only by accepted in-range loads, never reset.
  always_ff @(posedge clk) begin
    if (reset && load_accept && load_in_range) mem[wr_idx] <= load_data;
  end

  // State register with the captured address and wait counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state logic: capture on request, count down wait states, one RESP cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        if (fetch_start) begin
          addr_d = fetch_addr;
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    busy = (state_q != S_IDLE);
  end

  // Registered response: strobe, data/err and counter are all updated by the RESP cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_valid_q <= 1'b0;
      fetch_data_q  <= '0;
      fetch_err_q   <= 1'b0;
      load_ack_q    <= 1'b0;
      fetch_count_q <= 16'd0;
    end else begin
      fetch_valid_q <= (state_q == S_RESP);
      load_ack_q    <= load_accept;
      if (state_q == S_RESP) begin
        if (rd_in_range && par_ok) begin
          fetch_data_q <= rd_word;
          fetch_err_q  <= 1'b0;
        end else begin
          fetch_data_q <= HALT_WORD;
          fetch_err_q  <= 1'b1;
        end
        if (fetch_count_q != 16'hFFFF) fetch_count_q <= fetch_count_q + 16'd1;
      end
    end
  end

  assign fetch_valid = fetch_valid_q;
  assign fetch_data  = fetch_data_q;
  assign fetch_err   = fetch_err_q;
  assign load_ack    = load_ack_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_mem_responder.sv
// tb/tb_instr_mem_responder.sv - directed scoreboard bench for instr_mem_responder
module tb_instr_mem_responder;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int DEPTH = 200;
  localparam int WC = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          fetch_req = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic          load_we = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [DW-1:0] load_data = '0;
  logic          fetch_valid;
  logic [DW-1:0] fetch_data;
  logic          fetch_err;
  logic          busy;
  logic          load_ack;
  logic [15:0]   fetch_count;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_t;
  int   checks = 0;
  int   failures = 0;
  int   exp_cnt = 0;
  int   n;

  instr_mem_responder #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .WAIT_CYCLES(WC), .HALT_WORD(16'hF000)
  ) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_err(fetch_err),
    .busy(busy),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .load_ack(load_ack), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Response monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset && fetch_valid) begin
      check("valid_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_t = sb.pop_front();
        check("fetch_data", 32'(fetch_data), 32'(mon_t.data));
        check("fetch_err", 32'(fetch_err), 32'(mon_t.err));
      end
    end
  end

  task automatic push_exp(input logic [DW-1:0] d, input logic e);
    exp_t t;
    t.data = d;
    t.err  = e;
    sb.push_back(t);
  endtask

  // Counts negedges until a strobe is visible, bounded.
  task automatic wait_valid(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!fetch_valid && cnt < 20);
    if (!fetch_valid) check("timeout", 32'(fetch_valid), 32'd1);
  endtask

  task automatic do_load(input logic [AW-1:0] a, input logic [DW-1:0] d, input string tag);
    load_we = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_we = 1'b0;
    check({tag, "_ack_hi"}, 32'(load_ack), 32'd1);
    @(negedge clk);
    check({tag, "_ack_lo"}, 32'(load_ack), 32'd0);
  endtask

  task automatic fetch(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic e, input string tag);
    int lat;
    push_exp(d, e);
    fetch_req = 1'b1; fetch_addr = a;
    wait_valid(lat);
    fetch_req = 1'b0;
    exp_cnt++;
    check({tag, "_lat"}, 32'(lat), 32'(WC + 2));
    check({tag, "_cnt"}, 32'(fetch_count), 32'(exp_cnt));
    @(negedge clk);
    check({tag, "_strobe_1cyc"}, 32'(fetch_valid), 32'd0);
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(fetch_valid), 32'd0);
    check("rst_err", 32'(fetch_err), 32'd0);
    check("rst_data", 32'(fetch_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ack", 32'(load_ack), 32'd0);
    check("rst_cnt", 32'(fetch_count), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Load then single fetch with exact latency
    do_load(8'd0, 16'h1234, "ld0");
    fetch(8'd0, 16'h1234, 1'b0, "f0");

    // Back-to-back fetches with the request held
    do_load(8'd1, 16'hA001, "ld1");
    do_load(8'd2, 16'hA002, "ld2");
    do_load(8'd3, 16'hA003, "ld3");
    push_exp(16'h1234, 1'b0);
    push_exp(16'hA001, 1'b0);
    push_exp(16'hA002, 1'b0);
    push_exp(16'hA003, 1'b0);
    fetch_req = 1'b1; fetch_addr = 8'd0;
    for (int i = 0; i < 4; i++) begin
      wait_valid(n);
      exp_cnt++;
      check("b2b_period", 32'(n), 32'(WC + 2));
      check("b2b_cnt", 32'(fetch_count), 32'(exp_cnt));
      if (i < 3) fetch_addr = AW'(i + 1);
      else       fetch_req = 1'b0;
    end
    @(negedge clk);
    check("b2b_strobe_1cyc", 32'(fetch_valid), 32'd0);

    // Out of range: write acked but dropped, fetch returns halt word
    do_load(8'hFA, 16'h7777, "ld_oor");
    fetch(8'hFA, 16'hF000, 1'b1, "f_oor");

    // Load and fetch together: load wins, fetch one cycle later sees new word
    push_exp(16'hBEEF, 1'b0);
    load_we = 1'b1; load_addr = 8'd10; load_data = 16'hBEEF;
    fetch_req = 1'b1; fetch_addr = 8'd10;
    @(negedge clk);
    load_we = 1'b0;
    check("coll_ack", 32'(load_ack), 32'd1);
    check("coll_busy", 32'(busy), 32'd0);
    wait_valid(n);
    fetch_req = 1'b0;
    exp_cnt++;
    check("coll_lat", 32'(n + 1), 32'(WC + 3));
    check("coll_cnt", 32'(fetch_count), 32'(exp_cnt));
    @(negedge clk);

    // Load during WAIT is dropped
    do_load(8'd11, 16'h1111, "ld11");
    push_exp(16'h1111, 1'b0);
    fetch_req = 1'b1; fetch_addr = 8'd11;
    @(negedge clk);
    check("wait_busy", 32'(busy), 32'd1);
    load_we = 1'b1; load_addr = 8'd11; load_data = 16'h2222;
    @(negedge clk);
    load_we = 1'b0;
    check("wait_noack", 32'(load_ack), 32'd0);
    wait_valid(n);
    fetch_req = 1'b0;
    exp_cnt++;
    check("wait_lat", 32'(n + 2), 32'(WC + 2));
    @(negedge clk);
    fetch(8'd11, 16'h1111, 1'b0, "f11_again");

    // Reset in WAIT aborts the fetch
    fetch_req = 1'b1; fetch_addr = 8'd1;
    @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_valid", 32'(fetch_valid), 32'd0);
    check("arst_data", 32'(fetch_data), 32'd0);
    check("arst_err", 32'(fetch_err), 32'd0);
    check("arst_cnt", 32'(fetch_count), 32'd0);
    fetch_req = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_novalid", 32'(fetch_valid), 32'd0);
    end
    fetch(8'd0, 16'h1234, 1'b0, "f_after_rst");

    // Parity path
    do_load(8'd20, 16'h5A5A, "ld20");
`ifdef IMEM_PARITY_EN
    force dut.par_mem[20] = 1'b1;
    fetch(8'd20, 16'hF000, 1'b1, "f_par_bad");
    release dut.par_mem[20];
`else
    fetch(8'd20, 16'h5A5A, 1'b0, "f_nopar");
`endif

    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
